// File: rtl/gs_pkg.sv
// Shared types and helpers for the Goldschmidt inverse-square-root iterator.
package gs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_X0,
        ST_YY,
        ST_B,
        ST_YN,
        ST_XU,
        ST_YU,
        ST_DONE
    } gs_state_e;

    localparam int ITERS_MIN = 1;
    localparam int ITERS_MAX = 4;
    localparam int IW_MIN    = 3;

    // 3.0 expressed with qw fractional bits.
    function automatic logic [31:0] fx_three(input int qw);
        return 32'(3) << qw;
    endfunction

    function automatic bit iters_ok(input int iters);
        return (iters >= ITERS_MIN) && (iters <= ITERS_MAX);
    endfunction

endpackage

// File: rtl/gs_fx_mul.sv
// Signed fixed-point multiply: full product, floor shift by QW, saturate to W bits.
module gs_fx_mul #(
    parameter int IW = 4,
    parameter int QW = 12
) (
    input  logic [IW+QW-1:0] a,
    input  logic [IW+QW-1:0] b,
    output logic [IW+QW-1:0] p,
    output logic             ovf
);

    localparam int unsigned W = IW + QW;

    logic signed [2*W-1:0] prod_c;
    logic signed [2*W-1:0] shr_c;

    always_comb begin
        prod_c = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        shr_c  = prod_c >>> QW;
        // Result fits only if the bits above the W-bit sign all match it.
        ovf    = (shr_c[2*W-1:W-1] != {(W+1){shr_c[2*W-1]}});
        if (ovf) begin
            p = shr_c[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            p = shr_c[W-1:0];
        end
    end

endmodule

// File: rtl/gs_rsqrt_iter.sv
// Iterative Goldschmidt 1/sqrt(S) and sqrt(S) with a single shared saturating multiplier.
module gs_rsqrt_iter
    import gs_pkg::*;
#(
    parameter int IW    = 4,
    parameter int QW    = 12,
    parameter int ITERS = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW+QW-1:0] s,
    input  logic [IW+QW-1:0] y0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW+QW-1:0] rsqrt,
    output logic [IW+QW-1:0] sqrt,
    output logic             err,
    output logic             sat
);

    localparam int unsigned W = IW + QW;

    if (!iters_ok(ITERS) || (IW < IW_MIN)) begin : g_param_err
        $error("gs_rsqrt_iter: ITERS must be in 1..4 and IW must be at least 3");
    end

    gs_state_e    state_q;
    logic [W-1:0] b_q, x_q, y_q, yb_q, t_q;
    logic [2:0]   cnt_q;
    logic [W-1:0] rsqrt_q, sqrt_q;
    logic         err_q, sat_q, out_valid_q, in_ready_q;

    logic [W-1:0] mul_a_c, mul_b_c, mul_p_c;
    logic         mul_ovf_c;
    logic [W:0]   three_c, diff_c;
    logic [W-1:0] ysat_c, yn_d;
    logic         yn_ovf_c;

    // Operand steering for the shared multiplier.
    always_comb begin
        mul_a_c = '0;
        mul_b_c = '0;
        case (state_q)
            ST_X0:   begin mul_a_c = b_q;  mul_b_c = y_q;  end
            ST_YY:   begin mul_a_c = yb_q; mul_b_c = yb_q; end
            ST_B:    begin mul_a_c = b_q;  mul_b_c = t_q;  end
            ST_XU:   begin mul_a_c = x_q;  mul_b_c = yb_q; end
            ST_YU:   begin mul_a_c = y_q;  mul_b_c = yb_q; end
            default: begin mul_a_c = '0;   mul_b_c = '0;   end
        endcase
    end

    gs_fx_mul #(
        .IW(IW),
        .QW(QW)
    ) u_mul (
        .a  (mul_a_c),
        .b  (mul_b_c),
        .p  (mul_p_c),
        .ovf(mul_ovf_c)
    );

    // Y = (3.0 - b) >>> 1, subtraction one bit wider then saturated back to W.
    always_comb begin
        three_c  = (W+1)'(fx_three(QW));
        diff_c   = three_c - {b_q[W-1], b_q};
        yn_ovf_c = diff_c[W] ^ diff_c[W-1];
        if (yn_ovf_c) begin
            ysat_c = diff_c[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            ysat_c = diff_c[W-1:0];
        end
        yn_d = {ysat_c[W-1], ysat_c[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            b_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            yb_q        <= '0;
            t_q         <= '0;
            cnt_q       <= '0;
            rsqrt_q     <= '0;
            sqrt_q      <= '0;
            err_q       <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        b_q        <= s;
                        y_q        <= y0;
                        yb_q       <= y0;
                        sat_q      <= 1'b0;
                        err_q      <= 1'b0;
                        cnt_q      <= 3'(ITERS);
                        in_ready_q <= 1'b0;
                        state_q    <= ST_X0;
                    end
                end
                ST_X0: begin
                    // Non-positive radicand short-circuits to an error result.
                    if (b_q[W-1] || (b_q == '0)) begin
                        err_q       <= 1'b1;
                        rsqrt_q     <= '0;
                        sqrt_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        x_q     <= mul_p_c;
                        sat_q   <= sat_q | mul_ovf_c;
                        state_q <= ST_YY;
                    end
                end
                ST_YY: begin
                    t_q     <= mul_p_c;
                    sat_q   <= sat_q | mul_ovf_c;
                    state_q <= ST_B;
                end
                ST_B: begin
                    b_q     <= mul_p_c;
                    sat_q   <= sat_q | mul_ovf_c;
                    state_q <= ST_YN;
                end
                ST_YN: begin
                    yb_q    <= yn_d;
                    sat_q   <= sat_q | yn_ovf_c;
                    state_q <= ST_XU;
                end
                ST_XU: begin
                    x_q     <= mul_p_c;
                    sat_q   <= sat_q | mul_ovf_c;
                    state_q <= ST_YU;
                end
                ST_YU: begin
                    y_q   <= mul_p_c;
                    sat_q <= sat_q | mul_ovf_c;
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        rsqrt_q     <= mul_p_c;
                        sqrt_q      <= x_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_YY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign rsqrt     = rsqrt_q;
    assign sqrt      = sqrt_q;
    assign err       = err_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_gs_rsqrt_iter.sv
// Bench for gs_rsqrt_iter: one instance with ITERS=1 (index 0) and one with ITERS=2 (index 1).
module tb_gs_rsqrt_iter;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn;
    logic [1:0]          in_valid, in_ready, out_valid, out_ready, err, sat;
    logic [W-1:0]        s, y0;
    logic [1:0][W-1:0]   rsqrt, sqrt;

    gs_rsqrt_iter #(.IW(4), .QW(12), .ITERS(1)) u_dut_i1 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .s        (s),
        .y0       (y0),
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
        .rsqrt    (rsqrt[0]),
        .sqrt     (sqrt[0]),
        .err      (err[0]),
        .sat      (sat[0])
    );

    gs_rsqrt_iter #(.IW(4), .QW(12), .ITERS(2)) u_dut_i2 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .s        (s),
        .y0       (y0),
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
        .rsqrt    (rsqrt[1]),
        .sqrt     (sqrt[1]),
        .err      (err[1]),
        .sat      (sat[1])
    );

    typedef struct {
        int           dut;
        logic [W-1:0] s;
        logic [W-1:0] y0;
        logic [W-1:0] rsqrt;
        logic [W-1:0] sqrt;
        int           tol;
        bit           chk;
        bit           err;
        bit           sat;
        int           lat;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = (act > exp) ? act - exp : exp - act;
        n_checks++;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h +/- %0d", name, act, exp, tol);
        end
    endtask

    // Accept must happen on the next edge; returns cycles from accept to out_valid.
    task automatic wait_result(input int d, output int cyc);
        cyc = 0;
        while (out_valid[d] !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        int   d;
        int   cyc;
        vec_t e;
        d = v.dut;
        @(negedge clk);
        check($sformatf("v%0d_in_ready", idx), int'(in_ready[d]), 1);
        s = v.s;
        y0 = v.y0;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        exp_q.push_back(v);
        wait_result(d, cyc);
        e = exp_q.pop_front();
        check($sformatf("v%0d_latency", idx), cyc, e.lat);
        if (e.chk) begin
            check_tol($sformatf("v%0d_rsqrt", idx), int'(rsqrt[d]), int'(e.rsqrt), e.tol);
            check_tol($sformatf("v%0d_sqrt", idx), int'(sqrt[d]), int'(e.sqrt), e.tol);
        end
        check($sformatf("v%0d_err", idx), int'(err[d]), int'(e.err));
        check($sformatf("v%0d_sat", idx), int'(sat[d]), int'(e.sat));
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check($sformatf("v%0d_release_valid", idx), int'(out_valid[d]), 0);
        check($sformatf("v%0d_release_ready", idx), int'(in_ready[d]), 1);
    endtask

    initial begin
        int cyc;
        bit seen;

        resetn    = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        s         = '0;
        y0        = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_out_valid", d), int'(out_valid[d]), 0);
            check($sformatf("rst%0d_in_ready", d), int'(in_ready[d]), 1);
            check($sformatf("rst%0d_rsqrt", d), int'(rsqrt[d]), 0);
            check($sformatf("rst%0d_sqrt", d), int'(sqrt[d]), 0);
            check($sformatf("rst%0d_err", d), int'(err[d]), 0);
            check($sformatf("rst%0d_sat", d), int'(sat[d]), 0);
        end

        //          dut  s         y0        rsqrt     sqrt     tol chk err sat lat
        vecs[0] = '{0, 16'h4000, 16'h0800, 16'h0800, 16'h2000, 0, 1, 0, 0, 6};
        vecs[1] = '{0, 16'h2000, 16'h0C00, 16'h0B40, 16'h1680, 0, 1, 0, 0, 6};
        vecs[2] = '{0, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0, 1, 0, 0, 6};
        vecs[3] = '{0, 16'hF000, 16'h1234, 16'h0000, 16'h0000, 0, 1, 1, 0, 1};
        vecs[4] = '{1, 16'h2000, 16'h0C00, 16'h0B50, 16'h16A1, 4, 1, 0, 0, 11};
        vecs[5] = '{1, 16'h4000, 16'h0800, 16'h0800, 16'h2000, 0, 1, 0, 0, 11};
        vecs[6] = '{1, 16'h0000, 16'h0800, 16'h0000, 16'h0000, 0, 1, 1, 0, 1};
        vecs[7] = '{1, 16'h7000, 16'h7FFF, 16'h0000, 16'h0000, 0, 0, 0, 1, 11};
        vecs[8] = '{0, 16'h7000, 16'h7FFF, 16'h0000, 16'h0000, 0, 0, 0, 1, 6};
        vecs[9] = '{0, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0, 1, 0, 0, 6};

        for (int i = 0; i < 10; i++) begin
            apply(i, vecs[i]);
        end

        // Consumer stall in DONE with a competing operand offered.
        @(negedge clk);
        s = 16'h4000;
        y0 = 16'h0800;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_result(0, cyc);
        check("stall_latency", cyc, 6);
        s = 16'h1000;
        y0 = 16'h1000;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_out_valid", k), int'(out_valid[0]), 1);
            check($sformatf("stall%0d_rsqrt", k), int'(rsqrt[0]), 16'h0800);
            check($sformatf("stall%0d_sqrt", k), int'(sqrt[0]), 16'h2000);
            check($sformatf("stall%0d_err", k), int'(err[0]), 0);
            check($sformatf("stall%0d_sat", k), int'(sat[0]), 0);
            check($sformatf("stall%0d_in_ready", k), int'(in_ready[0]), 0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("stall_release_valid", int'(out_valid[0]), 0);
        check("stall_release_ready", int'(in_ready[0]), 1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid[0] === 1'b1 || in_ready[0] !== 1'b1) seen = 1'b1;
        end
        check("stall_no_ghost_accept", int'(seen), 0);

        // Reset asserted while the ITERS=2 instance sits in state B.
        @(negedge clk);
        s = 16'h2000;
        y0 = 16'h0C00;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("midrst_out_valid", int'(out_valid[1]), 0);
        check("midrst_in_ready", int'(in_ready[1]), 1);
        check("midrst_rsqrt", int'(rsqrt[1]), 0);
        check("midrst_sqrt", int'(sqrt[1]), 0);
        check("midrst_sat", int'(sat[1]), 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid[1] === 1'b1) seen = 1'b1;
        end
        check("midrst_no_result", int'(seen), 0);

        apply(10, vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gs_rsqrt_iter.md
GS_RSQRT_ITER -- requirements
Module: gs_rsqrt_iter

Interface
REQ-001 SHALL have parameter IW, default 4: integer bits of signed fixed-point format, sign included.
REQ-002 SHALL have parameter QW, default 12: fractional bits. W = IW+QW.
REQ-003 SHALL have parameter ITERS, default 2, legal range 1..4: number of Goldschmidt refinement iterations.
REQ-004 SHALL have clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have in_valid  input  1  operand offered.
REQ-007 SHALL have in_ready  output  1  block accepts an operand.
REQ-008 SHALL have s  input  W  signed radicand S.
REQ-009 SHALL have y0  input  W  signed initial estimate of 1/sqrt(S).
REQ-010 SHALL have out_valid  output  1  result held.
REQ-011 SHALL have out_ready  input  1  consumer takes the result.
REQ-012 SHALL have rsqrt  output  W  1/sqrt(S) estimate.
REQ-013 SHALL have sqrt  output  W  sqrt(S) estimate.
REQ-014 SHALL have err  output  1  S was <= 0.
REQ-015 SHALL have sat  output  1  at least one multiply saturated during this operation.

Function
REQ-016 SHALL accept an operand on a clk edge with in_valid && in_ready, capturing s into b and y0 into y and Y, and clearing sat and err.
REQ-017 SHALL drive in_ready = 1 only in state IDLE.
REQ-018 SHALL sequence the FSM IDLE -> X0 -> {YY -> B -> YN -> XU -> YU} x ITERS -> DONE -> IDLE, one cycle per state except DONE.
REQ-019 SHALL perform in X0: x = b*y. In YY: t = Y*Y. In B: b = b*t. In YN: Y = (3.0 - b) >>> 1. In XU: x = x*Y. In YU: y = y*Y, then decrement the iteration counter.
REQ-020 SHALL, in YU, go to YY if iterations remain, otherwise go to DONE.
REQ-021 SHALL assert out_valid exactly 1+5*ITERS cycles after the accept edge for S > 0.
REQ-022 SHALL, if s <= 0 at accept, go directly to DONE on the next edge with err=1 and rsqrt = sqrt = 0.
REQ-023 SHALL hold out_valid, rsqrt, sqrt, err and sat stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-024 SHALL ignore in_valid in every state except IDLE; back-to-back throughput is therefore one result per 3+5*ITERS cycles at best.
REQ-025 SHALL compute each multiply as the full 2W-bit signed product, arithmetic-shifted right by QW (truncation toward minus infinity), then saturated to the W-bit signed range; any saturation sets sat.
REQ-026 SHALL compute the YN subtraction at W+1 bits and saturate it before the shift; this saturation also sets sat.
REQ-027 SHALL share one multiplier instance across all multiplying states.

Reset
REQ-028 SHALL, with resetn low at a clk edge, enter IDLE and set out_valid=0, rsqrt=0, sqrt=0, err=0, sat=0 and the iteration counter to 0.
REQ-029 SHALL abandon any in-flight operation on reset, with no result emitted; in_ready=1 on the first cycle after release.

Structure
REQ-030 SHALL take the FSM state enum, the fixed-point constant helper (3.0 in IW.QW) and the ITERS range check from shared package gs_pkg.
REQ-031 SHALL place the saturating multiplier in combinational sub-module gs_fx_mul (params IW, QW; ports a, b, p, ovf).
REQ-032 SHALL flag an elaboration-time error if ITERS is outside 1..4 or IW < 3.

Verification (IW=4, QW=12)
REQ-033 SHALL test ITERS=1 with s=0x4000 (4.0), y0=0x0800: out_valid 6 cycles after accept, rsqrt=0x0800, sqrt=0x2000, err=0, sat=0.
REQ-034 SHALL test ITERS=2 with s=0x2000, y0=0x0C00: out_valid after 11 cycles, rsqrt within 4 LSB of 0x0B50, sqrt within 4 LSB of 0x16A1.
REQ-035 SHALL test s=0xF000 (-1.0) with y0 arbitrary: out_valid 1 cycle after accept, err=1, rsqrt=sqrt=0.
REQ-036 SHALL test out_ready held low 3 cycles in DONE: outputs stable, in_ready=0, and a concurrent in_valid is not accepted.
REQ-037 SHALL test resetn pulsed low during state B: next cycle out_valid=0, in_ready=1, and no result ever emitted for that operand.
REQ-038 SHALL test s=0x7000 (7.0) with y0=0x7FFF: sat=1 at DONE.
